// File: rtl/gpio_int_pkg.sv
// Shared encodings and reset constants for the GPIO interrupt detector.
// Debounce filter is compiled in only when GPIO_INT_DEBOUNCE_EN is defined.
package gpio_int_pkg;

    typedef enum logic {
        MODE_EDGE  = 1'b0,
        MODE_LEVEL = 1'b1
    } int_mode_e;

    typedef enum logic {
        POL_LOW  = 1'b0,
        POL_HIGH = 1'b1
    } int_pol_e;

    localparam logic RST_PIN = 1'b0;

    // Level mode compares the filtered pin against polarity; edge mode picks rise/fall/both.
    function automatic logic pin_event(
        input logic stab,
        input logic rise,
        input logic fall,
        input logic lvl,
        input logic pol,
        input logic both
    );
        logic w_ev;
        if (int_mode_e'(lvl) == MODE_LEVEL) begin
            w_ev = (stab == pol);
        end else if (both) begin
            w_ev = rise | fall;
        end else if (int_pol_e'(pol) == POL_HIGH) begin
            w_ev = rise;
        end else begin
            w_ev = fall;
        end
        return w_ev;
    endfunction

endpackage

// File: rtl/gpio_int_debounce.sv
// Per-pin 2-flop synchronizer, optional debounce (GPIO_INT_DEBOUNCE_EN) and edge history.
// Latency: stab follows sync2 after T+1 agreeing cycles (or directly without the macro); no backpressure.
module gpio_int_debounce
    import gpio_int_pkg::*;
#(
    parameter int DB_W = 4
) (
    input  logic            src_clk,
    input  logic            src_rstn,
    input  logic            i_pin,
    input  logic [DB_W-1:0] i_db_thr,
    output logic            o_stab,
    output logic            o_rise,
    output logic            o_fall
);

    logic r_sync1;
    logic r_sync2;
    logic r_stab_d;
    logic w_stab;

    always_ff @(posedge src_clk or negedge src_rstn) begin
        if (!src_rstn) begin
            r_sync1 <= RST_PIN;
            r_sync2 <= RST_PIN;
        end else begin
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
        end
    end

`ifdef GPIO_INT_DEBOUNCE_EN
    logic            r_stab;
    logic [DB_W-1:0] r_cnt;

    // >= keeps the count bounded even if the threshold is lowered mid-run.
    always_ff @(posedge src_clk or negedge src_rstn) begin
        if (!src_rstn) begin
            r_stab <= RST_PIN;
            r_cnt  <= '0;
        end else if (r_sync2 == r_stab) begin
            r_cnt <= '0;
        end else if (r_cnt >= i_db_thr) begin
            r_stab <= r_sync2;
            r_cnt  <= '0;
        end else begin
            r_cnt <= r_cnt + DB_W'(1);
        end
    end

    assign w_stab = r_stab;
`else
    logic w_unused_thr;
    assign w_unused_thr = ^i_db_thr;
    assign w_stab       = r_sync2;
`endif

    always_ff @(posedge src_clk or negedge src_rstn) begin
        if (!src_rstn) begin
            r_stab_d <= RST_PIN;
        end else begin
            r_stab_d <= w_stab;
        end
    end

    assign o_stab = w_stab;
    assign o_rise = w_stab & ~r_stab_d;
    assign o_fall = ~w_stab & r_stab_d;

endmodule

// File: rtl/gpio_int_detect.sv
// GPIO interrupt detector: per-pin edge/level events into a write-1-to-clear pending register.
// Latency: raw after N+3+T (N+2 without GPIO_INT_DEBOUNCE_EN), req one cycle later; no backpressure.
module gpio_int_detect
    import gpio_int_pkg::*;
#(
    parameter int DAT_W = 8,
    parameter int DB_W  = 4
) (
    input  logic             src_clk,
    input  logic             src_rstn,
    input  logic [DAT_W-1:0] i_gpio,
    input  logic [DAT_W-1:0] i_int_en,
    input  logic [DAT_W-1:0] i_int_mask,
    input  logic [DAT_W-1:0] i_int_lvl,
    input  logic [DAT_W-1:0] i_int_pol,
    input  logic [DAT_W-1:0] i_int_both,
    input  logic [DB_W-1:0]  i_db_thr,
    input  logic [DAT_W-1:0] i_clr,
    output logic [DAT_W-1:0] o_int_raw,
    output logic [DAT_W-1:0] o_int_stat,
    output logic             o_int_req
);

    logic [DAT_W-1:0] w_stab;
    logic [DAT_W-1:0] w_rise;
    logic [DAT_W-1:0] w_fall;
    logic [DAT_W-1:0] w_event;
    logic [DAT_W-1:0] r_int_raw;
    logic             r_int_req;

    for (genvar g = 0; g < DAT_W; g++) begin : g_pin
        gpio_int_debounce #(
            .DB_W (DB_W)
        ) u_db (
            .src_clk  (src_clk),
            .src_rstn (src_rstn),
            .i_pin    (i_gpio[g]),
            .i_db_thr (i_db_thr),
            .o_stab   (w_stab[g]),
            .o_rise   (w_rise[g]),
            .o_fall   (w_fall[g])
        );

        assign w_event[g] = pin_event(w_stab[g], w_rise[g], w_fall[g],
                                      i_int_lvl[g], i_int_pol[g], i_int_both[g]);
    end

    // Set beats clear; a disabled pin never holds a pending bit.
    always_ff @(posedge src_clk or negedge src_rstn) begin
        if (!src_rstn) begin
            r_int_raw <= '0;
            r_int_req <= 1'b0;
        end else begin
            r_int_raw <= i_int_en & (w_event | (r_int_raw & ~i_clr));
            r_int_req <= |o_int_stat;
        end
    end

    assign o_int_raw  = r_int_raw;
    assign o_int_stat = r_int_raw & ~i_int_mask;
    assign o_int_req  = r_int_req;

endmodule

// File: tb/tb_gpio_int_detect.sv
// Directed and random checks of gpio_int_detect against a sample-history reference model.
// Works with or without GPIO_INT_DEBOUNCE_EN; latency expectations follow the build.
module tb_gpio_int_detect;

    localparam int DAT_W = 8;
    localparam int DB_W  = 4;
    localparam int T_DIR = 3;
`ifdef GPIO_INT_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
    localparam int LAT = 3 + T_DIR;
`else
    localparam bit DEB = 1'b0;
    localparam int LAT = 2;
`endif

    logic             src_clk = 1'b0;
    logic             src_rstn;
    logic [DAT_W-1:0] gpio, en, mask, lvl, pol, both, clr;
    logic [DB_W-1:0]  thr;
    logic [DAT_W-1:0] raw, stat;
    logic             req;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 src_clk = ~src_clk;

    gpio_int_detect #(
        .DAT_W (DAT_W),
        .DB_W  (DB_W)
    ) dut (
        .src_clk    (src_clk),
        .src_rstn   (src_rstn),
        .i_gpio     (gpio),
        .i_int_en   (en),
        .i_int_mask (mask),
        .i_int_lvl  (lvl),
        .i_int_pol  (pol),
        .i_int_both (both),
        .i_db_thr   (thr),
        .i_clr      (clr),
        .o_int_raw  (raw),
        .o_int_stat (stat),
        .o_int_req  (req)
    );

    // Reference model: pin history as queues of samples seen at each clock edge.
    logic [DAT_W-1:0] in_q[$];
    logic [DAT_W-1:0] s2_q[$];
    logic [DAT_W-1:0] m_stab = '0, m_stab_d = '0, m_raw = '0;
    logic             m_req = 1'b0;
    logic [DAT_W-1:0] m_s2_old, m_s2_new, m_ev, m_stab_nx;
    int               m_run;

    always @(posedge src_clk or negedge src_rstn) begin
        if (!src_rstn) begin
            m_stab   = '0;
            m_stab_d = '0;
            m_raw    = '0;
            m_req    = 1'b0;
            in_q.delete();
            s2_q.delete();
        end else begin
            m_s2_old = (in_q.size() >= 2) ? in_q[in_q.size()-2] : '0;
            m_s2_new = (in_q.size() >= 1) ? in_q[in_q.size()-1] : '0;
            for (int p = 0; p < DAT_W; p++) begin
                if (lvl[p])
                    m_ev[p] = (m_stab[p] == pol[p]);
                else if (both[p])
                    m_ev[p] = (m_stab[p] != m_stab_d[p]);
                else if (pol[p])
                    m_ev[p] = m_stab[p] && !m_stab_d[p];
                else
                    m_ev[p] = !m_stab[p] && m_stab_d[p];
            end
            m_req = |(m_raw & ~mask);
            m_raw = en & (m_ev | (m_raw & ~clr));
            s2_q.push_back(m_s2_old);
            if (DEB) begin
                // A pin changes once T+1 consecutive samples disagree with the filtered value.
                for (int p = 0; p < DAT_W; p++) begin
                    m_run = 0;
                    for (int i = s2_q.size() - 1; i >= 0; i--) begin
                        if (s2_q[i][p] == m_stab[p]) break;
                        m_run++;
                    end
                    m_stab_nx[p] = (m_run >= int'(thr) + 1) ? ~m_stab[p] : m_stab[p];
                end
            end else begin
                m_stab_nx = m_s2_new;
            end
            m_stab_d = m_stab;
            m_stab   = m_stab_nx;
            in_q.push_back(gpio);
            if (in_q.size() > 24) void'(in_q.pop_front());
            if (s2_q.size() > 24) void'(s2_q.pop_front());
        end
    end

    task automatic chk(input string tag, input logic [DAT_W-1:0] obs, input logic [DAT_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick_chk(input string tag);
        @(posedge src_clk);
        #1;
        chk({tag, "/raw"}, raw, m_raw);
        chk({tag, "/stat"}, stat, m_raw & ~mask);
        chk({tag, "/req"}, {7'b0, req}, {7'b0, m_req});
    endtask

    initial begin
        src_rstn = 1'b0;
        gpio = '0; en = '0; mask = '0; lvl = '0; pol = '0; both = '0; clr = '0;
        thr  = DB_W'(T_DIR);
        repeat (3) @(posedge src_clk);
        #1;
        chk("rst_raw", raw, 8'h00);
        chk("rst_stat", stat, 8'h00);
        chk("rst_req", {7'b0, req}, 8'h00);
        src_rstn = 1'b1;

        // Rising edge on pin0: fixed latency to raw and req.
        en = 8'h01; pol = 8'h01;
        repeat (3) tick_chk("idle");
        gpio[0] = 1'b1;
        for (int j = 0; j <= LAT + 1; j++) begin
            tick_chk("rise0");
            chk("rise0_raw_lat", 8'(raw[0]), 8'(j >= LAT));
            chk("rise0_req_lat", 8'(req), 8'(j >= LAT + 1));
        end
        clr = 8'h01;
        tick_chk("clr0");
        clr = 8'h00;
        tick_chk("clr0_post");
        chk("clr0_raw", raw, 8'h00);

        // 3-cycle glitch on both-edge pin1 is filtered; 4-cycle pulse is not.
        en = 8'h02; both = 8'h02;
        gpio[1] = 1'b1;
        repeat (3) tick_chk("glitch");
        gpio[1] = 1'b0;
        repeat (12) tick_chk("glitch_wait");
        if (DEB) chk("glitch_raw", raw, 8'h00);
        clr = 8'hFF;
        tick_chk("glitch_clr");
        clr = 8'h00;
        gpio[1] = 1'b1;
        repeat (4) tick_chk("pulse4");
        gpio[1] = 1'b0;
        repeat (12) tick_chk("pulse4_wait");
        chk("pulse4_raw", raw, 8'h02);
        clr = 8'hFF;
        tick_chk("pulse4_clr");
        clr = 8'h00;

        // Level-low pin2 re-pends while low; clears once high.
        en = 8'h04; lvl = 8'h04; both = 8'h00; pol = 8'h00;
        repeat (2) tick_chk("lvl_low");
        chk("lvl_set", 8'(raw[2]), 8'h01);
        clr = 8'h04;
        tick_chk("lvl_clr_low");
        clr = 8'h00;
        chk("lvl_clr_held", 8'(raw[2]), 8'h01);
        gpio[2] = 1'b1;
        repeat (12) tick_chk("lvl_high");
        clr = 8'h04;
        tick_chk("lvl_clr_high");
        clr = 8'h00;
        tick_chk("lvl_after");
        chk("lvl_cleared", 8'(raw[2]), 8'h00);

        // Masked both-edge pin3 pends without a request until unmasked.
        en = 8'h08; lvl = 8'h00; both = 8'h08; mask = 8'h08;
        gpio[3] = 1'b1;
        repeat (LAT + 2) tick_chk("mask3");
        chk("mask3_raw", raw, 8'h08);
        chk("mask3_stat", stat, 8'h00);
        chk("mask3_req", 8'(req), 8'h00);
        mask = 8'h00;
        #1;
        chk("unmask3_stat", stat, 8'h08);
        tick_chk("unmask3");
        chk("unmask3_req", 8'(req), 8'h01);
        clr = 8'hFF;
        tick_chk("mask3_clr");
        clr = 8'h00;

        // Event and clear on the same cycle: set wins, clear applies afterwards.
        en = 8'h10; both = 8'h00; pol = 8'h10; clr = 8'h10;
        gpio[4] = 1'b1;
        for (int j = 0; j <= LAT + 1; j++) begin
            tick_chk("setclr4");
            chk("setclr4_raw", 8'(raw[4]), 8'(j == LAT));
        end
        clr = 8'h00;

        // Reset in the middle of a debounce count restarts the filter.
        en = 8'h20; pol = 8'h20;
        gpio[5] = 1'b1;
        repeat (3) tick_chk("midcnt");
        src_rstn = 1'b0;
        #2;
        chk("midrst_raw", raw, 8'h00);
        chk("midrst_stat", stat, 8'h00);
        chk("midrst_req", 8'(req), 8'h00);
        tick_chk("midrst_hold");
        src_rstn = 1'b1;
        for (int j = 0; j <= LAT; j++) begin
            tick_chk("restart5");
            chk("restart5_raw", 8'(raw[5]), 8'(j >= LAT));
        end

        // Random configuration, sparse pin toggles and clears against the model.
        for (int seg = 0; seg < 12; seg++) begin
            en   = 8'($urandom);
            mask = 8'($urandom);
            lvl  = 8'($urandom);
            pol  = 8'($urandom);
            both = 8'($urandom);
            thr  = DB_W'($urandom_range(0, 5));
            for (int c = 0; c < 30; c++) begin
                if ($urandom_range(0, 3) == 0) gpio = gpio ^ (8'($urandom) & 8'($urandom));
                clr = 8'($urandom) & 8'($urandom) & 8'($urandom);
                tick_chk("rand");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
